// File: rtl/axi_sram_responder.sv
// AXI4 slave fronting an internal byte-writable SRAM, one burst in flight.
// Ports: clock, arst_n, AXI4 AW/W/B/AR/R channels as axi_*_i / axi_*_o.
module axi_sram_responder #(
  parameter int SRAM_BYTES = 2048,
  parameter int DATA_WIDTH = 32,
  parameter int ADDRS      = 27,
  parameter int REQID      = 4
) (
  input  logic                    clock,
  input  logic                    arst_n,
  input  logic                    axi_awvalid_i,
  output logic                    axi_awready_o,
  input  logic [ADDRS-1:0]        axi_awaddr_i,
  input  logic [REQID-1:0]        axi_awid_i,
  input  logic [7:0]              axi_awlen_i,
  input  logic [1:0]              axi_awburst_i,
  input  logic                    axi_wvalid_i,
  output logic                    axi_wready_o,
  input  logic                    axi_wlast_i,
  input  logic [DATA_WIDTH/8-1:0] axi_wstrb_i,
  input  logic [DATA_WIDTH-1:0]   axi_wdata_i,
  output logic                    axi_bvalid_o,
  input  logic                    axi_bready_i,
  output logic [1:0]              axi_bresp_o,
  output logic [REQID-1:0]        axi_bid_o,
  input  logic                    axi_arvalid_i,
  output logic                    axi_arready_o,
  input  logic [ADDRS-1:0]        axi_araddr_i,
  input  logic [REQID-1:0]        axi_arid_i,
  input  logic [7:0]              axi_arlen_i,
  input  logic [1:0]              axi_arburst_i,
  output logic                    axi_rvalid_o,
  input  logic                    axi_rready_i,
  output logic                    axi_rlast_o,
  output logic [1:0]              axi_rresp_o,
  output logic [REQID-1:0]        axi_rid_o,
  output logic [DATA_WIDTH-1:0]   axi_rdata_o
);
  localparam int STRB  = DATA_WIDTH / 8;
  localparam int DEPTH = SRAM_BYTES / STRB;
  localparam int LSB   = $clog2(STRB);
  localparam int IW    = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    BRESP = 2'd2,
    READ  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0]            r_sync;
  logic                  w_rst_n;
  logic [IW-1:0]         r_idx;
  logic [REQID-1:0]      r_id;
  logic [7:0]            r_len;
  logic [1:0]            r_burst;
  logic [8:0]            r_wcnt;
  logic                  r_err;
  logic [8:0]            r_issue;
  logic                  r_rvalid;
  logic                  r_rlast;
  logic [DATA_WIDTH-1:0] r_rd_q;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic w_aw_hs, w_ar_hs, w_w_hs, w_b_hs, w_r_hs;
  logic w_incr, w_bad, w_inlen, w_we;
  logic w_issue, w_mem_re;
  logic w_unused;

  // Assert asynchronously, release two clocks later.
  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) r_sync <= 2'b00;
    else         r_sync <= {r_sync[0], 1'b1};
  end
  assign w_rst_n = r_sync[1];

  assign w_aw_hs = axi_awvalid_i & axi_awready_o;
  assign w_ar_hs = axi_arvalid_i & axi_arready_o;
  assign w_w_hs  = axi_wvalid_i  & axi_wready_o;
  assign w_b_hs  = axi_bvalid_o  & axi_bready_i;
  assign w_r_hs  = r_rvalid      & axi_rready_i;

  assign w_incr  = (r_burst == 2'b01);
  assign w_bad   = r_burst[1];
  assign w_inlen = (r_wcnt <= {1'b0, r_len});
  assign w_we    = w_w_hs & w_inlen & ~w_bad;

  // The read register doubles as the SRAM output, so refill when empty
  // or when the current beat is being taken.
  assign w_issue  = (r_state == READ) &
                    (~r_rvalid | axi_rready_i) &
                    (r_issue <= {1'b0, r_len});
  assign w_mem_re = w_issue & ~w_bad;

  assign w_unused = ^{axi_awaddr_i[ADDRS-1:IW+LSB], axi_awaddr_i[LSB-1:0],
                      axi_araddr_i[ADDRS-1:IW+LSB], axi_araddr_i[LSB-1:0]};

  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_aw_hs)      w_next = WRITE;
        else if (w_ar_hs) w_next = READ;
      end
      WRITE: if (w_w_hs && axi_wlast_i)  w_next = BRESP;
      BRESP: if (w_b_hs)                 w_next = IDLE;
      READ:  if (w_r_hs && r_rlast)      w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    axi_awready_o = w_rst_n & (r_state == IDLE) & axi_awvalid_i;
    axi_arready_o = w_rst_n & (r_state == IDLE) & axi_arvalid_i &
                    ~axi_awvalid_i;
    axi_wready_o  = (r_state == WRITE);
    axi_bvalid_o  = (r_state == BRESP);
    axi_bresp_o   = (axi_bvalid_o && (r_err || w_bad)) ? 2'b10 : 2'b00;
  end

  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_idx    <= '0;
      r_id     <= '0;
      r_len    <= '0;
      r_burst  <= '0;
      r_wcnt   <= '0;
      r_err    <= 1'b0;
      r_issue  <= '0;
      r_rvalid <= 1'b0;
      r_rlast  <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_idx   <= axi_awaddr_i[IW+LSB-1:LSB];
        r_id    <= axi_awid_i;
        r_len   <= axi_awlen_i;
        r_burst <= axi_awburst_i;
        r_wcnt  <= '0;
        r_err   <= 1'b0;
      end else if (w_ar_hs) begin
        r_idx   <= axi_araddr_i[IW+LSB-1:LSB];
        r_id    <= axi_arid_i;
        r_len   <= axi_arlen_i;
        r_burst <= axi_arburst_i;
        r_issue <= '0;
      end else if (w_w_hs) begin
        // Counter parks at len+1 so overrun beats are dropped.
        if (w_inlen) begin
          r_wcnt <= r_wcnt + 9'd1;
          if (w_incr) r_idx <= r_idx + IW'(1);
        end
        if (axi_wlast_i != (r_wcnt == {1'b0, r_len})) r_err <= 1'b1;
      end else if (w_issue) begin
        r_issue <= r_issue + 9'd1;
        r_rlast <= (r_issue == {1'b0, r_len});
        if (w_incr) r_idx <= r_idx + IW'(1);
      end
      if (w_issue)     r_rvalid <= 1'b1;
      else if (w_r_hs) r_rvalid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (w_we) begin
      for (int b = 0; b < STRB; b++) begin
        if (axi_wstrb_i[b]) r_mem[r_idx][b*8 +: 8] <= axi_wdata_i[b*8 +: 8];
      end
    end
    if (w_mem_re) r_rd_q <= r_mem[r_idx];
  end

  assign axi_rvalid_o = r_rvalid;
  assign axi_rlast_o  = r_rvalid & r_rlast;
  assign axi_rresp_o  = (r_rvalid && w_bad) ? 2'b10 : 2'b00;
  assign axi_rdata_o  = (r_rvalid && !w_bad) ? r_rd_q : '0;
  assign axi_rid_o    = r_id;
  assign axi_bid_o    = r_id;

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed bench for axi_sram_responder with a byte-level memory model
// and a per-cycle compare process on the B and R channels.
module tb_axi_sram_responder;
  localparam int SB    = 2048;
  localparam int DEPTH = SB / 4;

  logic        clock = 1'b0;
  logic        arst_n = 1'b1;
  logic        awvalid = 0, awready;
  logic [26:0] awaddr = 0;
  logic [3:0]  awid = 0;
  logic [7:0]  awlen = 0;
  logic [1:0]  awburst = 0;
  logic        wvalid = 0, wready, wlast = 0;
  logic [3:0]  wstrb = 0;
  logic [31:0] wdata = 0;
  logic        bvalid, bready = 0;
  logic [1:0]  bresp;
  logic [3:0]  bid;
  logic        arvalid = 0, arready;
  logic [26:0] araddr = 0;
  logic [3:0]  arid = 0;
  logic [7:0]  arlen = 0;
  logic [1:0]  arburst = 0;
  logic        rvalid, rready = 0, rlast;
  logic [1:0]  rresp;
  logic [3:0]  rid;
  logic [31:0] rdata;

  always #5 clock = ~clock;

  axi_sram_responder dut (
    .clock(clock), .arst_n(arst_n),
    .axi_awvalid_i(awvalid), .axi_awready_o(awready),
    .axi_awaddr_i(awaddr), .axi_awid_i(awid),
    .axi_awlen_i(awlen), .axi_awburst_i(awburst),
    .axi_wvalid_i(wvalid), .axi_wready_o(wready),
    .axi_wlast_i(wlast), .axi_wstrb_i(wstrb), .axi_wdata_i(wdata),
    .axi_bvalid_o(bvalid), .axi_bready_i(bready),
    .axi_bresp_o(bresp), .axi_bid_o(bid),
    .axi_arvalid_i(arvalid), .axi_arready_o(arready),
    .axi_araddr_i(araddr), .axi_arid_i(arid),
    .axi_arlen_i(arlen), .axi_arburst_i(arburst),
    .axi_rvalid_o(rvalid), .axi_rready_i(rready),
    .axi_rlast_o(rlast), .axi_rresp_o(rresp),
    .axi_rid_o(rid), .axi_rdata_o(rdata)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic [1:0]  r;
    logic [3:0]  id;
  } rbeat_t;
  typedef struct packed {
    logic [1:0] r;
    logic [3:0] id;
  } bexp_t;

  logic [31:0] mw [DEPTH];
  rbeat_t      rq[$];
  logic [31:0] rx[$];
  bexp_t       bq[$];
  bexp_t       brx[$];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  bit          mon_en = 0;

  function automatic int widx(input logic [26:0] a);
    return (int'(a) % SB) / 4;
  endfunction

  task automatic model_read(input logic [26:0] a, input logic [3:0] id,
                            input logic [7:0] len, input logic [1:0] bu);
    int base;
    rbeat_t e;
    base = widx(a);
    for (int i = 0; i <= int'(len); i++) begin
      e.id = id;
      e.l  = (i == int'(len));
      if (bu[1]) begin
        e.d = 32'h0;
        e.r = 2'b10;
      end else begin
        e.d = mw[(base + (bu == 2'b01 ? i : 0)) % DEPTH];
        e.r = 2'b00;
      end
      rq.push_back(e);
    end
  endtask

  task automatic do_write(input logic [26:0] a, input logic [3:0] id,
                          input logic [7:0] len, input logic [1:0] bu,
                          input int nb);
    int base, eff, w, n0;
    bit hs;
    bexp_t e;
    base = widx(a);
    eff  = (nb < int'(len) + 1) ? nb : int'(len) + 1;
    n0   = brx.size();
    e.id = id;
    e.r  = (bu[1] || nb != int'(len) + 1) ? 2'b10 : 2'b00;
    bq.push_back(e);
    if (!bu[1]) begin
      for (int i = 0; i < eff; i++) begin
        w = (base + (bu == 2'b01 ? i : 0)) % DEPTH;
        for (int b = 0; b < 4; b++)
          if (ws[i][b]) mw[w][b*8 +: 8] = wd[i][b*8 +: 8];
      end
    end
    awaddr = a; awid = id; awlen = len; awburst = bu; awvalid = 1;
    hs = 0;
    for (int t = 0; t < 50 && !hs; t++) begin
      @(negedge clock); hs = awready;
      @(posedge clock); #1;
    end
    chk("aw_handshake", hs, 1);
    awvalid = 0;
    for (int i = 0; i < nb; i++) begin
      wdata = wd[i]; wstrb = ws[i]; wlast = (i == nb - 1); wvalid = 1;
      hs = 0;
      for (int t = 0; t < 50 && !hs; t++) begin
        @(negedge clock); hs = wready;
        @(posedge clock); #1;
      end
      chk("w_handshake", hs, 1);
    end
    wvalid = 0; wlast = 0;
    for (int t = 0; t < 50 && brx.size() == n0; t++) @(posedge clock);
    #1;
    chk("b_received", brx.size(), n0 + 1);
  endtask

  task automatic do_read(input logic [26:0] a, input logic [3:0] id,
                         input logic [7:0] len, input logic [1:0] bu,
                         input int mode);
    int n0, k;
    bit hs;
    n0 = rx.size();
    model_read(a, id, len, bu);
    araddr = a; arid = id; arlen = len; arburst = bu; arvalid = 1;
    hs = 0;
    for (int t = 0; t < 50 && !hs; t++) begin
      @(negedge clock); hs = arready;
      @(posedge clock); #1;
    end
    chk("ar_handshake", hs, 1);
    arvalid = 0;
    k = 0;
    for (int t = 0; t < 300 && rx.size() < n0 + int'(len) + 1; t++) begin
      rready = (mode == 0) || (k % 3 == 0);
      k++;
      @(posedge clock); #1;
    end
    rready = 0;
    chk("r_beat_count", rx.size() - n0, int'(len) + 1);
  endtask

  int          cyc = 0;
  int          t_ar = 0;
  bit          pend = 0;
  bit          p_rv = 0, p_rr = 0, p_bv = 0, p_br = 0;
  logic [38:0] p_rbits = 0;

  always @(negedge clock) begin
    rbeat_t e;
    bexp_t  b;
    cyc++;
    if (!mon_en) begin
      pend = 0; p_rv = 0; p_bv = 0;
    end else begin
      if (arvalid && arready) begin t_ar = cyc; pend = 1; end
      if (pend && rvalid) begin
        chk("r_latency", cyc - t_ar, 2);
        pend = 0;
      end
      if (p_rv && !p_rr) begin
        chk("r_hold_valid", rvalid, 1);
        chk("r_hold_bits", {rdata, rlast, rresp, rid}, p_rbits);
      end
      if (p_bv && !p_br) chk("b_hold_valid", bvalid, 1);
      if (!rvalid) chk("rdata_idle", rdata, 0);
      if (rvalid) begin
        if (rq.size() == 0) chk("r_unexpected", 1, 0);
        else begin
          e = rq[0];
          chk("rdata", rdata, e.d);
          chk("rlast", rlast, e.l);
          chk("rresp", rresp, e.r);
          chk("rid", rid, e.id);
          if (rready) begin
            void'(rq.pop_front());
            rx.push_back(rdata);
          end
        end
      end
      if (bvalid && bready) begin
        if (bq.size() == 0) chk("b_unexpected", 1, 0);
        else begin
          chk("bresp", bresp, bq[0].r);
          chk("bid", bid, bq[0].id);
          void'(bq.pop_front());
        end
        b.r = bresp; b.id = bid;
        brx.push_back(b);
      end
      p_rv = rvalid; p_rr = rready;
      p_bv = bvalid; p_br = bready;
      p_rbits = {rdata, rlast, rresp, rid};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bit got;
    #2 arst_n = 0;
    awvalid = 1; arvalid = 1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_ready", {awready, arready, wready}, 0);
    chk("rst_valid", {bvalid, rvalid, rlast}, 0);
    chk("rst_data", {bresp, rresp, bid, rid, rdata}, 0);
    @(posedge clock); #1;
    awvalid = 0; arvalid = 0; arst_n = 1;
    repeat (4) @(posedge clock); #1;
    bready = 1; mon_en = 1;

    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + i; ws[i] = 4'hF; end
    do_write(27'h10, 4'd3, 8'd3, 2'b01, 4);
    chk("t1_bresp_lit", brx[brx.size()-1].r, 2'b00);
    n0 = rx.size();
    do_read(27'h10, 4'd3, 8'd3, 2'b01, 0);
    for (int i = 0; i < 4; i++) chk("t1_rdata_lit", rx[n0+i], 32'hA0 + i);

    wd[0] = 32'h11223344; ws[0] = 4'hF;
    do_write(27'h0, 4'd1, 8'd0, 2'b01, 1);
    wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
    do_write(27'h0, 4'd1, 8'd0, 2'b01, 1);
    do_read(27'h0, 4'd2, 8'd0, 2'b01, 0);
    chk("t2_strobe_lit", rx[rx.size()-1], 32'h11BB33DD);

    wd[0] = 32'hC0DE0001; wd[1] = 32'hC0DE0002;
    ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(27'(SB - 4), 4'd4, 8'd1, 2'b01, 2);
    do_read(27'h0, 4'd4, 8'd0, 2'b01, 0);
    chk("t3_wrap_lit", rx[rx.size()-1], 32'hC0DE0002);
    do_read(27'(SB), 4'd4, 8'd0, 2'b01, 0);
    chk("t3_alias_lit", rx[rx.size()-1], 32'hC0DE0002);

    mw[16] = 32'h5555AAAA;
    bq.push_back(bexp_t'({2'b00, 4'd5}));
    model_read(27'h40, 4'd6, 8'd0, 2'b01);
    n0 = rx.size();
    awaddr = 27'h40; awid = 5; awlen = 0; awburst = 2'b01; awvalid = 1;
    araddr = 27'h40; arid = 6; arlen = 0; arburst = 2'b01; arvalid = 1;
    bready = 0;
    @(negedge clock);
    chk("arb_awready", awready, 1);
    chk("arb_arready_idle", arready, 0);
    @(posedge clock); #1;
    awvalid = 0; wdata = 32'h5555AAAA; wstrb = 4'hF; wlast = 1; wvalid = 1;
    @(negedge clock);
    chk("arb_arready_write", arready, 0);
    @(posedge clock); #1;
    wvalid = 0; wlast = 0;
    @(negedge clock);
    chk("arb_bvalid", bvalid, 1);
    chk("arb_arready_bresp", arready, 0);
    @(posedge clock); #1;
    bready = 1;
    @(negedge clock);
    chk("arb_arready_bhs", arready, 0);
    @(posedge clock); #1;
    @(negedge clock);
    chk("arb_arready_go", arready, 1);
    @(posedge clock); #1;
    arvalid = 0; rready = 1;
    for (int t = 0; t < 20 && rx.size() == n0; t++) @(posedge clock);
    #1; rready = 0;
    chk("arb_r_count", rx.size(), n0 + 1);

    for (int i = 0; i < 8; i++) begin
      wd[i] = 32'hD0000000 | (i * 32'h11); ws[i] = 4'hF;
    end
    do_write(27'h100, 4'd9, 8'd7, 2'b01, 8);
    n0 = rx.size();
    do_read(27'h100, 4'd9, 8'd7, 2'b01, 1);
    chk("t5_last_lit", rx[n0+7], 32'hD0000077);

    wd[0] = 32'hE1; wd[1] = 32'hE2; ws[0] = 4'hF; ws[1] = 4'hF;
    do_write(27'h200, 4'd2, 8'd3, 2'b01, 2);
    chk("early_wlast_lit", brx[brx.size()-1].r, 2'b10);
    do_read(27'h200, 4'd2, 8'd1, 2'b01, 0);

    wd[0] = 32'h77;
    do_write(27'h304, 4'd4, 8'd0, 2'b01, 1);
    wd[0] = 32'hF1; wd[1] = 32'hF2;
    do_write(27'h300, 4'd4, 8'd0, 2'b01, 2);
    chk("late_wlast_lit", brx[brx.size()-1].r, 2'b10);
    do_read(27'h300, 4'd4, 8'd1, 2'b01, 0);
    chk("late_discard_lit", rx[rx.size()-1], 32'h77);

    wd[0] = 32'hDEAD0000; wd[1] = 32'hDEAD0001;
    do_write(27'h10, 4'd1, 8'd1, 2'b10, 2);
    chk("wrap_bresp_lit", brx[brx.size()-1].r, 2'b10);
    wd[0] = 32'hDEAD0002;
    do_write(27'h10, 4'd1, 8'd0, 2'b11, 1);
    n0 = rx.size();
    do_read(27'h10, 4'd1, 8'd3, 2'b01, 0);
    chk("wrap_nochange_lit", rx[n0], 32'hA0);
    do_read(27'h10, 4'd1, 8'd1, 2'b10, 0);
    chk("wrap_rdata_lit", rx[rx.size()-1], 32'h0);

    wd[0] = 32'h1; wd[1] = 32'h2;
    do_write(27'h24, 4'd7, 8'd1, 2'b00, 2);
    do_read(27'h24, 4'd7, 8'd1, 2'b00, 0);
    chk("fixed_lit", rx[rx.size()-1], 32'h2);

    mon_en = 0;
    araddr = 27'h100; arid = 4'd8; arlen = 8'd7; arburst = 2'b01;
    arvalid = 1; rready = 0;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clock); got = arready;
      @(posedge clock); #1;
    end
    arvalid = 0;
    chk("rst_ar_hs", got, 1);
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clock); got = rvalid;
    end
    chk("rst_rv_seen", got, 1);
    @(posedge clock); #1;
    arst_n = 0;
    @(negedge clock);
    chk("abort_valids", {awready, arready, wready, bvalid, rvalid, rlast}, 0);
    chk("abort_data", {bresp, rresp, bid, rid, rdata}, 0);
    repeat (2) @(posedge clock); #1;
    arst_n = 1;
    repeat (4) @(posedge clock); #1;
    rq.delete();
    mon_en = 1;
    wd[0] = 32'hFEEDBEEF; ws[0] = 4'hF;
    do_write(27'h0, 4'hA, 8'd0, 2'b01, 1);
    do_read(27'h0, 4'hA, 8'd0, 2'b01, 0);
    chk("post_rst_lit", rx[rx.size()-1], 32'hFEEDBEEF);

    repeat (3) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
